// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, control levels,
// state encoding and the number of bytes per instruction.
package if_fetch_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;
    localparam int BYTE_W   = 8;

    localparam logic RESET_ENABLE = 1'b1;
    localparam logic JUMP_ENABLE  = 1'b1;

    localparam logic [2:0] INST_BYTE_CNT = 3'd4;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_byte_assembler.sv
// Collects little-endian bytes into an instruction word; byte k ends up in
// bits [8k+7:8k] once all bytes of the word have been shifted in.
module if_byte_assembler
    import if_fetch_pkg::*;
#(
    parameter int INST_W = INST_LEN
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cap,
    input  logic [7:0]        rx_byte,
    output logic [2:0]        recv_cnt,
    output logic [INST_W-1:0] word
);

    logic [INST_W-1:0] asm_p1;

    // Each new byte enters at the top, so the first byte lands in the low lane.
    assign word = {rx_byte, asm_p1[INST_W-1:BYTE_W]};

    always_ff @(posedge clk) begin
        if (clr) begin
            recv_cnt <= '0;
            asm_p1   <= '0;
        end else if (cap) begin
            recv_cnt <= recv_cnt + 3'd1;
            asm_p1   <= word;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: reads one instruction a byte at a time over the
// shared memory port, presents it to the decoder and honours jump redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_LEN,
    parameter int                INST_W   = INST_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              stall_i,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_data_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o
);

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [2:0]        issue_cnt;
    logic              pend_p1;

    logic              vld_p2;
    logic [INST_W-1:0] inst_p2;
    logic [ADDR_W-1:0] pc_p2;

    logic [2:0]        recv_cnt;
    logic [INST_W-1:0] word_p1;

    logic rst_hit;
    logic jump_hit;
    logic issue;
    logic capture;
    logic last_byte;
    logic accept;
    logic asm_clr;

    logic [1:0] unused_jump_lo;

    assign unused_jump_lo = jump_addr_i[1:0];

    assign rst_hit  = (rst == RESET_ENABLE);
    assign jump_hit = (jump_flag_i == JUMP_ENABLE);

    assign issue     = (state == IF_FETCH) && (issue_cnt < INST_BYTE_CNT)
                       && !mem_busy_i && !rst_hit;
    // A byte in flight across a redirect or reset belongs to the old stream.
    assign capture   = (state == IF_FETCH) && pend_p1 && !rst_hit && !jump_hit;
    assign last_byte = capture && (recv_cnt == INST_BYTE_CNT - 3'd1);
    assign accept    = (state == IF_HOLD) && vld_p2 && !stall_i
                       && !jump_hit && !rst_hit;
    assign asm_clr   = rst_hit || jump_hit || accept;

    assign mem_req_o  = issue;
    assign mem_addr_o = issue ? fetch_pc + ADDR_W'(issue_cnt) : '0;

    assign pc_o         = pc_p2;
    assign inst_o       = inst_p2;
    assign inst_valid_o = vld_p2;

    // p1: byte returned one cycle after its request
    if_byte_assembler #(
        .INST_W (INST_W)
    ) u_asm (
        .clk      (clk),
        .clr      (asm_clr),
        .cap      (capture),
        .rx_byte  (mem_data_i),
        .recv_cnt (recv_cnt),
        .word     (word_p1)
    );

    // p2: assembled instruction presented to the decoder
    always_ff @(posedge clk) begin
        if (rst_hit) begin
            state     <= IF_FETCH;
            fetch_pc  <= RESET_PC;
            issue_cnt <= '0;
            pend_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            inst_p2   <= '0;
            pc_p2     <= RESET_PC;
        end else if (jump_hit) begin
            state     <= IF_FETCH;
            fetch_pc  <= align_pc(jump_addr_i);
            issue_cnt <= '0;
            pend_p1   <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            case (state)
                IF_FETCH: begin
                    pend_p1 <= issue;
                    if (issue) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (last_byte) begin
                        inst_p2 <= word_p1;
                        pc_p2   <= fetch_pc;
                        vld_p2  <= 1'b1;
                        state   <= IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    pend_p1 <= 1'b0;
                    if (accept) begin
                        fetch_pc  <= fetch_pc + ADDR_W'(INST_BYTE_CNT);
                        issue_cnt <= '0;
                        vld_p2    <= 1'b0;
                        state     <= IF_FETCH;
                    end
                end
                default: begin
                    state <= IF_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a byte memory with one-cycle latency and a
// cycle-by-cycle script of stalls, busy cycles, redirects and resets.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        stall_i;
    logic        mem_busy_i;
    logic [7:0]  mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    logic [7:0] mem [0:8191];
    int n_tests = 0;
    int n_fail  = 0;

    if_fetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .stall_i      (stall_i),
        .mem_busy_i   (mem_busy_i),
        .mem_data_i   (mem_data_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_data_i <= mem_req_o ? mem[mem_addr_o[12:0]] : 8'hEE;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(mem_req_o), 32'h1);
        chk({tag, "_addr"}, mem_addr_o, addr);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, 32'(mem_req_o), 32'h0);
        chk({tag, "_addr"}, mem_addr_o, 32'h0);
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc,
                           input logic [31:0] inst);
        chk({tag, "_vld"}, 32'(inst_valid_o), 32'(vld));
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_inst"}, inst_o, inst);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'hEE;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h02; mem[6] = 8'h20; mem[7] = 8'h00;
        mem[8] = 8'h33; mem[9] = 8'h86; mem[10] = 8'hA5; mem[11] = 8'h00;
        mem['h40] = 8'h6F; mem['h41] = 8'h00; mem['h42] = 8'h00; mem['h43] = 8'h00;
        mem['h1000] = 8'hB7; mem['h1001] = 8'h10; mem['h1002] = 8'h00; mem['h1003] = 8'h00;

        rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        stall_i = 1'b0; mem_busy_i = 1'b0;
        repeat (2) step;
        mid;
        chk_idle("rst");
        chk_out("rst", 1'b0, 32'h0, 32'h0);

        // Basic fetch from RESET_PC: c0..c5
        step; rst = 1'b0; mid; chk_req("c0", 32'h0); chk("c0_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_req("c1", 32'h1);
        step; mid; chk_req("c2", 32'h2);
        step; mid; chk_req("c3", 32'h3);
        step; mid; chk_idle("c4"); chk("c4_vld", 32'(inst_valid_o), 32'h0);
        step; stall_i = 1'b1; mid; chk_out("c5", 1'b1, 32'h0, 32'h00100513); chk_idle("c5");

        // Stall holds outputs c6..c7; released in c8
        step; mid; chk_out("stall1", 1'b1, 32'h0, 32'h00100513); chk_idle("stall1");
        step; mid; chk_out("stall2", 1'b1, 32'h0, 32'h00100513);
        step; stall_i = 1'b0; mid; chk_out("rel", 1'b1, 32'h0, 32'h00100513);
        step; mid; chk_req("c9", 32'h4); chk("c9_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_req("c10", 32'h5);
        step; mid; chk_req("c11", 32'h6);
        step; mid; chk_req("c12", 32'h7);
        step; mid; chk_idle("c13");
        step; mid; chk_out("c14", 1'b1, 32'h4, 32'h00200293);

        // Busy in third cycle of the fetch at 8
        step; mid; chk_req("b0", 32'h8);
        step; mid; chk_req("b1", 32'h9);
        step; mem_busy_i = 1'b1; mid; chk_idle("b2");
        step; mem_busy_i = 1'b0; mid; chk_req("b3", 32'hA);
        step; mid; chk_req("b4", 32'hB);
        step; mid; chk_idle("b5"); chk("b5_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_out("b6", 1'b1, 32'h8, 32'h00A58633);

        // Redirect to unaligned 0x1003 in third cycle of the fetch at 0xC
        step; mid; chk_req("j0", 32'hC);
        step; mid; chk_req("j1", 32'hD);
        step; jump_flag_i = 1'b1; jump_addr_i = 32'h1003; mid; chk_req("j2", 32'hE);
        step; jump_flag_i = 1'b0; mid; chk_req("j3", 32'h1000); chk("j3_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_req("j4", 32'h1001);
        step; mid; chk_req("j5", 32'h1002);
        step; mid; chk_req("j6", 32'h1003);
        step; mid; chk_idle("j7"); chk("j7_vld", 32'(inst_valid_o), 32'h0);
        step; jump_flag_i = 1'b1; jump_addr_i = 32'h40; mid;
        chk_out("j8", 1'b1, 32'h1000, 32'h000010B7);

        // Jump coincident with acceptance drops the held instruction
        step; jump_flag_i = 1'b0; mid; chk_req("ja0", 32'h40); chk("ja0_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_req("ja1", 32'h41);
        step; mid; chk_req("ja2", 32'h42);
        step; mid; chk_req("ja3", 32'h43);
        step; mid; chk_idle("ja4");
        step; stall_i = 1'b1; mid; chk_out("ja5", 1'b1, 32'h40, 32'h0000006F);
        step; stall_i = 1'b0; mid; chk_out("ja6", 1'b1, 32'h40, 32'h0000006F);

        // Reset after two bytes of the fetch at 0x44
        step; mid; chk_req("r0", 32'h44);
        step; mid; chk_req("r1", 32'h45);
        step; mid; chk_req("r2", 32'h46);
        step; rst = 1'b1; mid; chk_idle("r3");
        step; rst = 1'b0; mid; chk_req("r4", 32'h0); chk_out("r4", 1'b0, 32'h0, 32'h0);
        step; mid; chk_req("r5", 32'h1);
        step; mid; chk_req("r6", 32'h2);
        step; mid; chk_req("r7", 32'h3);
        step; mid; chk_idle("r8"); chk("r8_vld", 32'(inst_valid_o), 32'h0);
        step; mid; chk_out("r9", 1'b1, 32'h0, 32'h00100513);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
